// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX: 32 steps per divide,
// returns {remainder, quotient} and holds the pipeline with a stall request meanwhile.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  input  logic               hold_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  // Upper WIDTH+1 bits: partial remainder; lower WIDTH bits: dividend shifting out, quotient shifting in.
  logic [2*WIDTH:0]   part_q, part_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH+1:0]   diff;
  logic               ge;
  logic [WIDTH:0]     rem_new;
  logic [WIDTH-1:0]   quo_new, quo_fix, rem_fix;

  assign abs1 = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Trial subtraction on the shifted remainder; a clear borrow bit means the divisor fits.
  assign diff    = part_q[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
  assign ge      = ~diff[WIDTH+1];
  assign rem_new = ge ? diff[WIDTH:0] : part_q[2*WIDTH-1:WIDTH-1];
  assign quo_new = {part_q[WIDTH-2:0], ge};
  assign quo_fix = qsign_q ? -quo_new : quo_new;
  assign rem_fix = rsign_q ? -rem_new[WIDTH-1:0] : rem_new[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      part_q    <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      part_q    <= part_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    part_d    = part_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    result_d  = result_q;
    if (annul_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state_d = S_DIVZERO;
            end else begin
              divisor_d = abs2;
              part_d    = {{(WIDTH+1){1'b0}}, abs1};
              qsign_d   = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              rsign_d   = signed_i & opdata1_i[WIDTH-1];
              cnt_d     = '0;
              state_d   = S_ON;
            end
          end
        end
        S_DIVZERO: begin
          result_d = '0;
          state_d  = S_END;
        end
        S_ON: begin
          part_d = {rem_new, quo_new};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            result_d = {rem_fix, quo_fix};
            state_d  = S_END;
          end
        end
        S_END: begin
          if (!hold_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    result_o   = result_q;
    ready_o    = (state_q == S_END);
    busy_o     = (state_q != S_IDLE);
    stallreq_o = start_i & ~annul_i & (state_q != S_END);
  end

endmodule
